// File: rtl/dcache_assoc.sv
// Write-back, write-allocate, N-way set-associative data cache with per-set
// round-robin replacement and a flush walk that writes back every dirty line.
module dcache_assoc #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 32,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  input  logic              flush_i,
  output logic              flush_done_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [2:0]        dbg_state_o
);
  localparam int OFF  = $clog2(LINE_W / 8);
  localparam int IDX  = $clog2(SETS);
  localparam int TAG  = ADDR_W - IDX - OFF;
  localparam int WSEL = $clog2(LINE_W / 32);
  localparam int VPW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int SCW  = $clog2(SETS * WAYS);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITEBACK, S_REFILL, S_FLUSH_SCAN, S_FLUSH_WB
  } state_t;

  logic              r_valid [SETS][WAYS];
  logic              r_dirty [SETS][WAYS];
  logic [TAG-1:0]    r_tag   [SETS][WAYS];
  logic [LINE_W-1:0] r_line  [SETS][WAYS];
  logic [VPW-1:0]    r_vptr  [SETS];

  state_t         r_state;
  logic [IDX-1:0] r_idx;
  logic [TAG-1:0] r_req_tag;
  logic [VPW-1:0] r_vway;
  logic [SCW-1:0] r_scan;
  logic           r_flush_pend;
  logic           r_flush_done;

  logic [IDX-1:0]    w_idx;
  logic [TAG-1:0]    w_tag;
  logic [WSEL-1:0]   w_word;
  logic              w_access;
  logic              w_hit;
  logic [VPW-1:0]    w_hit_way;
  logic [LINE_W-1:0] w_hit_line;
  logic              w_idle_hit;
  logic              w_miss;
  logic [VPW-1:0]    w_vic_way;
  logic              w_vic_dirty;
  logic [IDX-1:0]    w_scan_set;
  logic [VPW-1:0]    w_scan_way;
  logic              w_scan_last;
  logic              w_scan_dirty;
  logic              w_flush_go;
  logic              w_unused;

  assign w_idx    = p1_addr_i[OFF +: IDX];
  assign w_tag    = p1_addr_i[OFF+IDX +: TAG];
  assign w_word   = p1_addr_i[2 +: WSEL];
  assign w_unused = ^p1_addr_i[1:0];
  assign w_access = p1_MemRead_i | p1_MemWrite_i;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit && r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = VPW'(w);
      end
    end
  end

  assign w_hit_line  = r_line[w_idx][w_hit_way];
  assign w_idle_hit  = (r_state == S_IDLE) && w_access && w_hit;
  assign w_miss      = (r_state == S_IDLE) && w_access && !w_hit;
  assign w_vic_way   = r_vptr[w_idx];
  assign w_vic_dirty = r_valid[w_idx][w_vic_way] && r_dirty[w_idx][w_vic_way];

  // Flush counter enumerates lines as set*WAYS + way.
  assign w_scan_set   = IDX'(r_scan / WAYS);
  assign w_scan_way   = VPW'(r_scan % WAYS);
  assign w_scan_last  = (r_scan == SCW'(SETS * WAYS - 1));
  assign w_scan_dirty = r_valid[w_scan_set][w_scan_way] && r_dirty[w_scan_set][w_scan_way];
  assign w_flush_go   = (r_state == S_IDLE) && !w_access && (flush_i || r_flush_pend);

  assign p1_stall_o   = (r_state != S_IDLE) || w_miss;
  assign p1_data_o    = (w_idle_hit && !p1_MemWrite_i) ? w_hit_line[{w_word, 5'b0} +: 32] : 32'h0;
  assign flush_done_o = r_flush_done;
  assign dbg_state_o  = r_state;

  // Memory handshake: enable is held with a stable address/data/write from the
  // first cycle of a memory state through the cycle in which mem_ack_i is high.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (r_state)
      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {r_tag[r_idx][r_vway], r_idx, {OFF{1'b0}}};
        mem_data_o   = r_line[r_idx][r_vway];
      end
      S_REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {r_req_tag, r_idx, {OFF{1'b0}}};
      end
      S_FLUSH_WB: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {r_tag[w_scan_set][w_scan_way], w_scan_set, {OFF{1'b0}}};
        mem_data_o   = r_line[w_scan_set][w_scan_way];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_req_tag    <= '0;
      r_vway       <= '0;
      r_scan       <= '0;
      r_flush_pend <= 1'b0;
      r_flush_done <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_vptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
        end
      end
    end else begin
      r_flush_done <= 1'b0;
      if (w_flush_go)   r_flush_pend <= 1'b0;
      else if (flush_i) r_flush_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_idle_hit && p1_MemWrite_i) begin
            r_dirty[w_idx][w_hit_way] <= 1'b1;
          end else if (w_miss) begin
            r_idx     <= w_idx;
            r_req_tag <= w_tag;
            r_vway    <= w_vic_way;
            r_state   <= w_vic_dirty ? S_WRITEBACK : S_REFILL;
          end else if (w_flush_go) begin
            r_scan  <= '0;
            r_state <= S_FLUSH_SCAN;
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) r_state <= S_REFILL;
        end
        S_REFILL: begin
          if (mem_ack_i) begin
            r_valid[r_idx][r_vway] <= 1'b1;
            r_dirty[r_idx][r_vway] <= 1'b0;
            if (WAYS > 1) r_vptr[r_idx] <= r_vptr[r_idx] + 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_FLUSH_SCAN: begin
          if (w_scan_dirty) begin
            r_state <= S_FLUSH_WB;
          end else if (w_scan_last) begin
            r_flush_done <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_scan <= r_scan + 1'b1;
          end
        end
        S_FLUSH_WB: begin
          if (mem_ack_i) begin
            r_dirty[w_scan_set][w_scan_way] <= 1'b0;
            if (w_scan_last) begin
              r_flush_done <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_scan  <= r_scan + 1'b1;
              r_state <= S_FLUSH_SCAN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line storage carries no reset; validity alone decides what is usable.
  always_ff @(posedge clk_i) begin
    if (w_idle_hit && p1_MemWrite_i) begin
      r_line[w_idx][w_hit_way][{w_word, 5'b0} +: 32] <= p1_data_i;
    end else if ((r_state == S_REFILL) && mem_ack_i) begin
      r_line[r_idx][r_vway] <= mem_data_i;
      r_tag[r_idx][r_vway]  <= r_req_tag;
    end
  end
endmodule

// File: tb/tb_dcache_assoc.sv
// Bench for dcache_assoc: directed scenarios plus random loads/stores checked
// against a flat memory image and a per-set round-robin residency model.
module tb_dcache_assoc;
  localparam int LW = 256;
  localparam int NS = 32;
  localparam int NW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [31:0]   p1_addr_i, p1_data_i, p1_data_o;
  logic          p1_MemRead_i, p1_MemWrite_i, p1_stall_o;
  logic          flush_i, flush_done_o;
  logic [LW-1:0] mem_data_i, mem_data_o;
  logic          mem_ack_i, mem_enable_o, mem_write_o;
  logic [31:0]   mem_addr_o;
  logic [2:0]    dbg_state_o;

  logic [31:0]   dm_addr, dm_data_o, dm_maddr;
  logic          dm_read, dm_stall, dm_fdone, dm_ack, dm_en, dm_we;
  logic [LW-1:0] dm_rline, dm_wline;
  logic [2:0]    dm_dbg;

  dcache_assoc dut (
    .clk_i(clk_i), .rst_i(rst_i), .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i), .p1_data_o(p1_data_o),
    .p1_stall_o(p1_stall_o), .flush_i(flush_i), .flush_done_o(flush_done_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .mem_data_o(mem_data_o),
    .mem_addr_o(mem_addr_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .dbg_state_o(dbg_state_o)
  );

  dcache_assoc #(.WAYS(1)) dut_dm (
    .clk_i(clk_i), .rst_i(rst_i), .p1_addr_i(dm_addr), .p1_data_i(32'h0),
    .p1_MemRead_i(dm_read), .p1_MemWrite_i(1'b0), .p1_data_o(dm_data_o),
    .p1_stall_o(dm_stall), .flush_i(1'b0), .flush_done_o(dm_fdone),
    .mem_data_i(dm_rline), .mem_ack_i(dm_ack), .mem_data_o(dm_wline),
    .mem_addr_o(dm_maddr), .mem_enable_o(dm_en), .mem_write_o(dm_we),
    .dbg_state_o(dm_dbg)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_bad = 0;
  int force_lat = 0, lat_acc = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0, dm_rd_cnt = 0;
  logic [31:0]   last_wr_addr = '0, last_rd_addr = '0;
  logic [LW-1:0] last_wr_data = '0;
  logic [LW-1:0] bmem [int unsigned];
  logic [LW-1:0] arch [int unsigned];
  bit            m_valid [NS][NW];
  bit            m_dirty [NS][NW];
  int unsigned   m_tag   [NS][NW];
  int            m_ptr   [NS];

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] init_line(input int unsigned la);
    logic [LW-1:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = 32'h5A00_0000 ^ 32'(la << 4) ^ 32'(w);
    return r;
  endfunction

  function automatic logic [LW-1:0] bline(input int unsigned la);
    return bmem.exists(la) ? bmem[la] : init_line(la);
  endfunction

  function automatic logic [LW-1:0] arch_line(input int unsigned la);
    return arch.exists(la) ? arch[la] : init_line(la);
  endfunction

  // Memory responder: acks after a random (or forced) number of enable cycles.
  initial begin : responder
    int cnt, lat;
    int unsigned la;
    cnt = 0; lat = 1;
    mem_ack_i = 1'b0; mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (mem_enable_o && rst_i) begin
        if (cnt == 0) lat = (force_lat > 0) ? force_lat : $urandom_range(1, 4);
        cnt++;
        if (cnt == lat) begin
          mem_ack_i = 1'b1;
          lat_acc += cnt;
          cnt = 0;
          la = mem_addr_o >> 5;
          if (mem_write_o) begin
            wr_cnt++;
            last_wr_addr = mem_addr_o;
            last_wr_data = mem_data_o;
            chk("wb_line_data", mem_data_o, arch_line(la));
            bmem[la] = mem_data_o;
          end else begin
            rd_cnt++;
            last_rd_addr = mem_addr_o;
            mem_data_i = bline(la);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : dm_responder
    dm_ack = 1'b0; dm_rline = '0;
    forever begin
      @(negedge clk_i);
      if (dm_ack) dm_ack = 1'b0;
      else if (dm_en && rst_i) begin
        dm_ack = 1'b1;
        dm_rline = init_line(dm_maddr >> 5);
        if (!dm_we) dm_rd_cnt++;
      end
    end
  end

  always @(negedge clk_i) if (flush_done_o) done_cnt++;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < NW; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = 0; end
    end
  endtask

  task automatic access(input bit st, input bit both, input logic [31:0] addr,
                        input logic [31:0] data, input bit pulse);
    int unsigned la, set, tag;
    int way, wd, n, wr0, rd0;
    bit hit, exp_wb;
    logic [31:0] exp_wb_addr, exp_ld;
    logic [LW-1:0] line;
    la = addr >> 5; set = la % NS; tag = la / NS; wd = (addr >> 2) & 7;
    hit = 0; way = 0; exp_wb = 0; exp_wb_addr = '0;
    for (int w = 0; w < NW; w++)
      if (m_valid[set][w] && m_tag[set][w] == tag) begin hit = 1; way = w; end
    if (!hit) begin
      way = m_ptr[set];
      exp_wb = m_valid[set][way] && m_dirty[set][way];
      exp_wb_addr = ((m_tag[set][way] * NS) + set) << 5;
      m_valid[set][way] = 1; m_dirty[set][way] = 0; m_tag[set][way] = tag;
      m_ptr[set] = (m_ptr[set] + 1) % NW;
    end
    line = arch_line(la);
    exp_ld = st ? 32'h0 : line[wd*32 +: 32];
    wr0 = wr_cnt; rd0 = rd_cnt; lat_acc = 0;
    @(negedge clk_i);
    p1_addr_i = addr; p1_data_i = data;
    p1_MemWrite_i = st; p1_MemRead_i = !st || both;
    n = 0;
    #1;
    while (p1_stall_o && n < 400) begin
      if (pulse && n == 0) flush_i = 1'b1;
      if (pulse && n == 1) flush_i = 1'b0;
      n++;
      @(negedge clk_i);
      #1;
    end
    flush_i = 1'b0;
    chk("stall_cycles", n, hit ? 0 : 1 + lat_acc);
    chk("load_data", p1_data_o, exp_ld);
    chk("wb_count", wr_cnt - wr0, exp_wb);
    chk("rd_count", rd_cnt - rd0, hit ? 0 : 1);
    if (exp_wb) chk("wb_addr", last_wr_addr, exp_wb_addr);
    if (!hit) chk("rd_addr", last_rd_addr, la << 5);
    @(posedge clk_i);
    #1;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    if (st) begin
      line[wd*32 +: 32] = data;
      arch[la] = line;
      m_dirty[set][way] = 1;
    end
  endtask

  task automatic do_flush(input bit already);
    int dcnt, wr0, d0, n;
    dcnt = 0;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        if (m_valid[s][w] && m_dirty[s][w]) begin dcnt++; m_dirty[s][w] = 0; end
    wr0 = wr_cnt; d0 = done_cnt;
    if (!already) begin
      @(negedge clk_i);
      flush_i = 1'b1;
      @(negedge clk_i);
      #1;
      chk("flush_stall", p1_stall_o, 1'b1);
      flush_i = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 3000) begin @(negedge clk_i); #1; n++; end
    repeat (3) @(negedge clk_i);
    #1;
    chk("flush_done_pulses", done_cnt - d0, 1);
    chk("flush_writes", wr_cnt - wr0, dcnt);
    chk("flush_stall_release", p1_stall_o, 1'b0);
  endtask

  initial begin : stimulus
    int wr_before, rd0, n;
    logic [31:0] a;
    logic [LW-1:0] il;
    rst_i = 1'b0; flush_i = 1'b0;
    p1_addr_i = '0; p1_data_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    dm_addr = '0; dm_read = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("rst_mem_enable", mem_enable_o, 1'b0);
    chk("rst_mem_write", mem_write_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_data", mem_data_o, '0);
    chk("rst_p1_data", p1_data_o, 32'h0);
    chk("rst_stall", p1_stall_o, 1'b0);
    chk("rst_flush_done", flush_done_o, 1'b0);

    // Clean miss with a 10-cycle memory, then an immediate hit.
    force_lat = 10;
    access(0, 0, 32'h0000_0004, 32'h0, 0);
    chk("first_rd_addr", last_rd_addr, 32'h0);
    force_lat = 0;
    access(0, 0, 32'h0000_0004, 32'h0, 0);

    // Store then reload in the same line.
    access(1, 0, 32'h0000_0008, 32'hDEAD_BEEF, 0);
    access(0, 0, 32'h0000_0008, 32'h0, 0);

    // Conflict eviction in set 0.
    access(0, 0, 32'h0000_0400, 32'h0, 0);
    access(0, 0, 32'h0000_0800, 32'h0, 0);
    chk("conflict_wb_addr", last_wr_addr, 32'h0);
    chk("conflict_wb_word2", last_wr_data[95:64], 32'hDEAD_BEEF);
    access(0, 0, 32'h0000_0400, 32'h0, 0);

    // Three dirty lines in distinct sets, then flush.
    access(1, 0, 32'h0000_0020, 32'h1111_0001, 0);
    access(1, 0, 32'h0000_0044, 32'h2222_0002, 0);
    access(1, 0, 32'h0000_0068, 32'h3333_0003, 0);
    wr_before = wr_cnt;
    do_flush(0);
    chk("flush_three_writes", wr_cnt - wr_before, 3);
    access(0, 0, 32'h0000_0020, 32'h0, 0);
    access(0, 0, 32'h0000_0044, 32'h0, 0);
    access(0, 0, 32'h0000_0068, 32'h0, 0);
    access(0, 0, 32'h0000_0420, 32'h0, 0);
    access(0, 0, 32'h0000_0820, 32'h0, 0);

    // Flush pulse arriving during a refill is held until the cache is idle.
    access(1, 0, 32'h0000_0084, 32'hCAFE_F00D, 0);
    force_lat = 3;
    access(0, 0, 32'h0000_0C00, 32'h0, 1);
    force_lat = 0;
    do_flush(1);

    // Reset in the middle of a refill.
    force_lat = 30;
    @(negedge clk_i);
    p1_addr_i = 32'h0000_01C0; p1_MemRead_i = 1'b1;
    repeat (4) @(negedge clk_i);
    #1;
    chk("refill_active", mem_enable_o, 1'b1);
    chk("refill_is_read", mem_write_o, 1'b0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("reset_abandons_txn", mem_enable_o, 1'b0);
    p1_MemRead_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    force_lat = 0;
    model_reset();
    arch = bmem;
    rd0 = rd_cnt;
    access(0, 0, 32'h0000_0044, 32'h0, 0);
    chk("reload_after_reset_misses", rd_cnt - rd0, 1);

    // Random loads/stores over 4 tags x 4 sets to force evictions.
    for (int i = 0; i < 150; i++) begin
      bit st, both;
      st = 1'($urandom_range(0, 1));
      both = st && ($urandom_range(0, 7) == 0);
      a = 32'($urandom_range(0, 3) * 32'h400 + $urandom_range(0, 3) * 32'h20 + $urandom_range(0, 7) * 4);
      access(st, both, a, $urandom, 0);
      if ($urandom_range(0, 19) == 0) do_flush(0);
    end
    do_flush(0);

    // Direct-mapped build: alternating conflicting loads always miss.
    for (int i = 0; i < 6; i++) begin
      a = (i % 2 == 1) ? 32'h0000_0400 : 32'h0000_0000;
      il = init_line(a >> 5);
      rd0 = dm_rd_cnt;
      @(negedge clk_i);
      dm_addr = a; dm_read = 1'b1;
      n = 0;
      #1;
      while (dm_stall && n < 100) begin n++; @(negedge clk_i); #1; end
      chk("dm_stall_cycles", n, 2);
      chk("dm_load_data", dm_data_o, il[31:0]);
      chk("dm_read_issued", dm_rd_cnt - rd0, 1);
      @(posedge clk_i);
      #1;
      dm_read = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dcache_assoc.md
# dcache_assoc

Parametrised write-back, write-allocate, N-way set-associative data cache for the MEM stage of the pipelined CPU, between the EX_MEM/MEM_WB registers and the line-wide data memory. It generalises the current direct-mapped data cache in three ways: sets, ways and line width are configurable, each set has round-robin replacement, and a flush handshake writes back every dirty line. `p1_stall_o` freezes the whole pipeline while a miss or flush is in progress.

## Interface
- `ADDR_W`, 32: byte-address width.
- `LINE_W`, 256: line width in bits. Power of two, at least 64; words per line = `LINE_W/32`.
- `SETS`, 32: number of sets. Power of two, at least 2.
- `WAYS`, 2: associativity, one of 1, 2 or 4.
- Derived widths: `OFF = log2(LINE_W/8)`, `IDX = log2(SETS)`, `TAG = ADDR_W-IDX-OFF`.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-low reset.
- `p1_addr_i`  in  ADDR_W  byte address; bits [1:0] are ignored.
- `p1_data_i`  in  32  store data.
- `p1_MemRead_i`  in  1  load request.
- `p1_MemWrite_i`  in  1  store request.
- `p1_data_o`  out  32  load data.
- `p1_stall_o`  out  1  pipeline stall.
- `flush_i`  in  1  request write-back of all dirty lines.
- `flush_done_o`  out  1  one-cycle pulse when a flush completes.
- `mem_data_i`  in  LINE_W  refill line.
- `mem_ack_i`  in  1  one-cycle memory completion.
- `mem_data_o`  out  LINE_W  write-back line.
- `mem_addr_o`  out  ADDR_W  line-aligned address; low OFF bits are 0.
- `mem_enable_o`  out  1  memory request.
- `mem_write_o`  out  1  1 = write, 0 = read.

## Operation
- Per-line state: valid bit, dirty bit, tag and line data. Per-set state: a victim pointer of `log2(WAYS)` bits.
- FSM states: IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB.
- Access definition: an access is pending when `p1_MemRead_i` or `p1_MemWrite_i` is high. If both are high, the access is treated as a store.
- Hit definition: the indexed set has a way with valid=1 and a matching tag.
- IDLE, hit:
  - `p1_stall_o` = 0.
  - On a load, `p1_data_o` = addressed word, combinationally in the same cycle.
  - On a store, the addressed word is replaced and dirty is set to 1 at the clock edge.
- IDLE, miss:
  - `p1_stall_o` = 1 combinationally.
  - The victim is the way at the set's victim pointer.
  - Next state is WRITEBACK if the victim has valid=1 and dirty=1, otherwise REFILL.
- WRITEBACK:
  - Drives `mem_enable_o`=1, `mem_write_o`=1, `mem_addr_o`={victim tag, index, 0}, `mem_data_o`=victim line.
  - Holds these until `mem_ack_i`, then moves to REFILL.
- REFILL:
  - Drives `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`={request tag, index, 0}.
  - On `mem_ack_i`: the victim way gets line=`mem_data_i`, valid=1, dirty=0 and the new tag; the set's victim pointer increments modulo WAYS; next state is IDLE.
  - Back in IDLE the access now hits and completes normally, including the store merge for a store miss.
- Flush entry: `flush_i` is sampled only in IDLE when no access is pending. A pending access has priority. A `flush_i` pulse seen while busy is latched and serviced on the next idle cycle with no pending access.
- FLUSH_SCAN:
  - Walks a {set, way} counter from 0 to `SETS*WAYS-1`, one line per cycle, with `p1_stall_o`=1.
  - A dirty line moves to FLUSH_WB, which performs the same bus write as WRITEBACK, clears dirty on ack, and returns to scan at the next line.
  - Valid bits and victim pointers are unchanged.
  - After the last line: `flush_done_o`=1 for one cycle, then IDLE.
- Memory may return `mem_ack_i` at any latency of 1 cycle or more. An ack outside WRITEBACK, REFILL or FLUSH_WB is ignored.

## Timing
- Reset values (rst_i=0 at an edge): state IDLE; all valid, dirty and victim pointers 0; flush latch 0.
- Output values in reset and in idle: `mem_enable_o`, `mem_write_o`, `flush_done_o` = 0; `mem_addr_o`, `mem_data_o`, `p1_data_o` = 0. `p1_data_o` is also 0 whenever there is no load hit.
- `mem_enable_o` handshake: high from the first cycle of a memory state through the ack cycle, low the cycle after. There is never a gap inside a transaction.
- Clean miss: with the ack in the k-th enable cycle, `p1_stall_o` is high for exactly k+1 cycles.
- Dirty miss: stall is 1 + k_wb + k_rf cycles.
- Read hit: zero added latency.
- Reset mid-transaction: the transaction is abandoned and `mem_enable_o` is 0 in the cycle after the reset edge. Dirty data is lost.
- WAYS=1: the victim pointer is absent and behaviour is direct-mapped.

## Test plan
- Clean read miss: LINE_W=256, SETS=32, WAYS=2; reset, then load 0x0000_0004 with ack after 10 enable cycles -> one read at 0x0000_0000, stall for 11 cycles, `p1_data_o` = line word 1. An immediate reload of the same address -> no stall.
- Store and reload: store 0xDEADBEEF to 0x0000_0008, then load 0x0000_0008 -> returns 0xDEADBEEF with no stall and no memory traffic.
- Conflict eviction: dirty 0x000, then load 0x400, then load 0x800 (all index 0) -> first a write at 0x000 whose line word 2 = 0xDEADBEEF, then a read at 0x800. After that, 0x400 still hits.
- Flush: create 3 dirty lines in distinct sets and pulse `flush_i` -> exactly 3 memory writes, one `flush_done_o` pulse, and a later load of those addresses hits with no write-back on eviction.
- Reset during REFILL: assert rst_i=0 mid-transaction -> `mem_enable_o`=0 on the next cycle, and a reload of a previously cached address misses.
- Direct-mapped build: WAYS=1, alternate loads of 0x000 and 0x400 -> every access misses and issues a read.
